// File: rtl/ser_pkg.sv
// Types and sizing helpers shared by the serial transmitter (PISO) and its matching receiver (SIPO).
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Counter width of at least one bit, even when n needs no bits at all.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period pacing: one-cycle bit_end strobe on the last clk of every CLKS_PER_BIT-cycle bit.
module bit_tick_gen
  import ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TC_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Down-counter; terminal count is zero. With CLKS_PER_BIT=1 it sits at zero permanently.
  assign bit_end = en & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TC_RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? TC_RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= TC_RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and zero-gap back-to-back frames.
//   state | meaning
//   IDLE  | waiting for a word; load_ready=1, line quiet
//   SHIFT | frame in flight; ser_out = head of shift register
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [BW-1:0]    bit_cnt_q;
  logic [BW-1:0]    bit_cnt_d;

  logic shifting;
  logic bit_end;
  logic accept;
  logic head;

  assign shifting = (state_q == SHIFT);
  assign head     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Outputs decode state and counters only, so load_valid never reaches the serial side.
  assign done       = shifting & bit_end & (bit_cnt_q == LAST_BIT);
  assign load_ready = ~shifting | done;
  assign ser_valid  = shifting;
  assign ser_out    = shifting & head;
  assign accept     = load_valid & load_ready;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (shifting),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      state_d   = SHIFT;
      shreg_d   = load_data;
      bit_cnt_d = '0;
    end else if (done) begin
      state_d = IDLE;
    end else if (shifting && bit_end) begin
      shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
      bit_cnt_d = bit_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Three transmitter configurations on shared stimulus, each checked every cycle against a frame-level model.
module tb_piso_serializer;

  localparam int NI = 3;
  localparam int W  = 8;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;

  logic [NI-1:0] ready_w;
  logic [NI-1:0] sout_w;
  logic [NI-1:0] sval_w;
  logic [NI-1:0] done_w;

  int cpb  [NI] = '{1, 3, 1};
  bit msbf [NI] = '{1'b1, 1'b1, 1'b0};

  // Model: is a frame active, which cycle of it are we in, and which word it carries.
  bit           m_act  [NI];
  int           m_pos  [NI];
  logic [W-1:0] m_word [NI];

  int n_checks = 0;
  int n_pass   = 0;

  piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_msb_c1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_w[0]),
    .load_data(load_data), .ser_out(sout_w[0]), .ser_valid(sval_w[0]), .done(done_w[0]));

  piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(3), .MSB_FIRST(1'b1)) u_msb_c3 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_w[1]),
    .load_data(load_data), .ser_out(sout_w[1]), .ser_valid(sval_w[1]), .done(done_w[1]));

  piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u_lsb_c1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_w[2]),
    .load_data(load_data), .ser_out(sout_w[2]), .ser_valid(sval_w[2]), .done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_done(input int i);
    return m_act[i] && (m_pos[i] == W * cpb[i] - 1);
  endfunction

  function automatic logic m_ready(input int i);
    return !m_act[i] || m_done(i);
  endfunction

  function automatic logic m_bit(input int i);
    int idx;
    logic [W-1:0] wd;
    idx = m_pos[i] / cpb[i];
    wd  = m_word[i];
    if (!m_act[i]) return 1'b0;
    return msbf[i] ? wd[W-1-idx] : wd[idx];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("u%0d.load_ready", i), 32'(ready_w[i]), 32'(m_ready(i)));
      check_eq($sformatf("u%0d.ser_valid", i),  32'(sval_w[i]),  32'(m_act[i]));
      check_eq($sformatf("u%0d.ser_out", i),    32'(sout_w[i]),  32'(m_bit(i)));
      check_eq($sformatf("u%0d.done", i),       32'(done_w[i]),  32'(m_done(i)));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      m_act[i]  = 1'b0;
      m_pos[i]  = 0;
      m_word[i] = '0;
    end
  endtask

  task automatic model_step(input logic lv, input logic [W-1:0] d);
    bit rdy [NI];
    for (int i = 0; i < NI; i++) rdy[i] = m_ready(i);
    for (int i = 0; i < NI; i++) begin
      if (lv && rdy[i]) begin
        m_act[i]  = 1'b1;
        m_pos[i]  = 0;
        m_word[i] = d;
      end else if (m_act[i]) begin
        if (m_pos[i] == W * cpb[i] - 1) m_act[i] = 1'b0;
        else m_pos[i]++;
      end
    end
  endtask

  // Called at a falling edge; drives inputs for the next rising edge and checks after it.
  task automatic cycle(input logic lv, input logic [W-1:0] d);
    load_valid = lv;
    load_data  = d;
    model_step(lv, d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, $urandom_range(0, 255));
  endtask

  // Reset asserted between edges: outputs must fall without waiting for a clock.
  task automatic async_reset();
    load_valid = 1'b0;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    model_clear();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // Single 0xA5 frame, long enough for the 3-clk-per-bit instance to finish.
    cycle(1'b1, 8'hA5);
    idle_cycles(30);

    // Ignored mid-frame load of 0xFF, then 0x3C offered on the 1-clk instances' done cycle.
    cycle(1'b1, 8'hA5);
    idle_cycles(3);
    cycle(1'b1, 8'hFF);
    idle_cycles(3);
    cycle(1'b1, 8'h3C);
    idle_cycles(40);

    // LSB-first single-one pattern.
    cycle(1'b1, 8'h01);
    idle_cycles(30);

    // Reset mid-frame after three bits of 0xFF, then confirm the line stays quiet.
    cycle(1'b1, 8'hFF);
    idle_cycles(3);
    async_reset();
    idle_cycles(10);

    // Continuous valid: every instance should chain frames with no gap.
    for (int k = 0; k < 60; k++) cycle(1'b1, $urandom_range(0, 255));
    idle_cycles(30);

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 255));
    end
    idle_cycles(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
